// File: rtl/tx_cpu_fifo.sv
// CPU-to-transmit byte buffer: byte or full-word CPU writes into a circular store,
// drained one byte per cycle into the downstream TX FIFO while it reports space.
module tx_cpu_fifo #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned BYTES      = 2,
  parameter bit          LITTLE_END = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_byte,
  input  logic                         wr_word,
  input  logic                         flush,
  input  logic                         fifo_has_space,
  input  logic [8*BYTES-1:0]           data,
  output logic [7:0]                   q,
  output logic                         pop,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] BYTES_L = LVL_W'(BYTES);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [LVL_W-1:0] level_nxt;
  logic             overflow_nxt;

  logic [LVL_W-1:0] free;
  logic [LVL_W-1:0] n_wr;
  logic             do_byte, do_word, reject;

  logic [7:0]       word_byte [BYTES];
  logic [PTR_W-1:0] wr_idx    [BYTES];
  logic [DEPTH-1:0] mem_we;
  logic [7:0]       mem_wd    [DEPTH];

  // Status outputs depend only on registered state; fifo_has_space reaches pop only.
  always_comb begin
    free  = DEPTH_L - level;
    empty = (level == '0);
    full  = (free < BYTES_L);
    pop   = fifo_has_space & ~empty;
    q     = empty ? '0 : mem[rd_ptr];
  end

  // word_byte[0] is the first byte out, which is also the single-byte lane.
  always_comb begin
    for (int unsigned k = 0; k < BYTES; k++) begin
      word_byte[k] = LITTLE_END ? data[8*k +: 8] : data[8*(BYTES-1-k) +: 8];
      wr_idx[k]    = wr_ptr + PTR_W'(k);
    end
  end

  always_comb begin
    do_byte = ~flush & wr_byte & (free != '0);
    do_word = ~flush & ~wr_byte & wr_word & (free >= BYTES_L);
    reject  = ~flush & ((wr_byte & (free == '0)) |
                        (~wr_byte & wr_word & (free < BYTES_L)));
    n_wr    = do_byte ? LVL_W'(1) : (do_word ? BYTES_L : '0);
  end

  always_comb begin
    mem_we = '0;
    for (int unsigned i = 0; i < DEPTH; i++) mem_wd[i] = '0;
    if (do_byte) begin
      mem_we[wr_ptr] = 1'b1;
      mem_wd[wr_ptr] = word_byte[0];
    end
    if (do_word) begin
      for (int unsigned k = 0; k < BYTES; k++) begin
        mem_we[wr_idx[k]] = 1'b1;
        mem_wd[wr_idx[k]] = word_byte[k];
      end
    end
  end

  always_comb begin
    if (flush) begin
      wr_ptr_nxt   = '0;
      rd_ptr_nxt   = '0;
      level_nxt    = '0;
      overflow_nxt = 1'b0;
    end else begin
      wr_ptr_nxt   = wr_ptr + PTR_W'(n_wr);
      rd_ptr_nxt   = rd_ptr + PTR_W'(pop);
      level_nxt    = level + n_wr - LVL_W'(pop);
      overflow_nxt = overflow | reject;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      level    <= level_nxt;
      overflow <= overflow_nxt;
    end
  end

  // Storage carries no reset; the level counter alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (mem_we[i]) mem[i] <= mem_wd[i];
    end
  end

  a_level_bound : assert property (@(posedge clk) disable iff (!reset_n) level <= DEPTH_L);

endmodule

// File: tb/tb_tx_cpu_fifo.sv
// Bench for tx_cpu_fifo: both byte orders side by side, checked by a byte-queue model
// plus a hand-computed vector table and directed wrap / async-reset sequences.
module tb_tx_cpu_fifo;
  localparam int DEPTH = 4;
  localparam int BYTES = 2;
  localparam int DW    = 8 * BYTES;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_byte, wr_word, flush, fhs;
  logic [DW-1:0] data;
  logic [7:0]    q_o     [2];
  logic          pop_o   [2];
  logic          empty_o [2];
  logic          full_o  [2];
  logic          ovf_o   [2];
  logic [LW-1:0] level_o [2];

  always #5 clk = ~clk;

  tx_cpu_fifo #(.DEPTH(DEPTH), .BYTES(BYTES), .LITTLE_END(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .wr_byte(wr_byte), .wr_word(wr_word), .flush(flush),
    .fifo_has_space(fhs), .data(data), .q(q_o[0]), .pop(pop_o[0]), .empty(empty_o[0]),
    .full(full_o[0]), .level(level_o[0]), .overflow(ovf_o[0]));

  tx_cpu_fifo #(.DEPTH(DEPTH), .BYTES(BYTES), .LITTLE_END(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .wr_byte(wr_byte), .wr_word(wr_word), .flush(flush),
    .fifo_has_space(fhs), .data(data), .q(q_o[1]), .pop(pop_o[1]), .empty(empty_o[1]),
    .full(full_o[1]), .level(level_o[1]), .overflow(ovf_o[1]));

  int errors = 0;
  int checks = 0;

  // Reference: index 0 models MS-byte-first, index 1 models LS-byte-first.
  logic [7:0] mq [2][$];
  logic       mo;
  logic [7:0] drained [2][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] out_byte(input int d, input logic [DW-1:0] v, input int k);
    logic [DW-1:0] s;
    s = (d == 0) ? (v >> (8 * (BYTES - 1 - k))) : (v >> (8 * k));
    return s[7:0];
  endfunction

  task automatic check_state(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_q%0d", tag, d), 32'(q_o[d]), (mq[d].size() > 0) ? 32'(mq[d][0]) : 32'h0);
      chk($sformatf("%s_level%0d", tag, d), 32'(level_o[d]), 32'(mq[d].size()));
      chk($sformatf("%s_empty%0d", tag, d), 32'(empty_o[d]), 32'(mq[d].size() == 0));
      chk($sformatf("%s_full%0d", tag, d), 32'(full_o[d]), 32'((DEPTH - mq[d].size()) < BYTES));
      chk($sformatf("%s_ovf%0d", tag, d), 32'(ovf_o[d]), 32'(mo));
    end
  endtask

  // Inputs are already driven; samples pop, advances the model, clocks, then checks state.
  task automatic cycle();
    int free;
    bit pm;
    #1;
    free = DEPTH - mq[0].size();
    pm = fhs && (mq[0].size() > 0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("pop%0d", d), 32'(pop_o[d]), 32'(pm));
      if (pop_o[d]) drained[d].push_back(q_o[d]);
    end
    if (flush) begin
      for (int d = 0; d < 2; d++) mq[d].delete();
      mo = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (pm) void'(mq[d].pop_front());
        if (wr_byte) begin
          if (free >= 1) mq[d].push_back(out_byte(d, data, 0));
        end else if (wr_word) begin
          if (free >= BYTES) for (int k = 0; k < BYTES; k++) mq[d].push_back(out_byte(d, data, k));
        end
      end
      if ((wr_byte && free < 1) || (!wr_byte && wr_word && free < BYTES)) mo = 1'b1;
    end
    @(posedge clk);
    #1;
    check_state("st");
  endtask

  typedef struct {
    logic          wb, ww, fl, sp;
    logic [DW-1:0] d;
    logic [7:0]    q0, q1;
    logic [LW-1:0] lv;
    logic          ov, em, fu;
  } vec_t;
  vec_t tv[$];

  task automatic add(input logic wb, ww, fl, sp, input logic [DW-1:0] d,
                     input logic [7:0] q0, q1, input int lv, input logic ov, em, fu);
    vec_t v;
    v.wb = wb; v.ww = ww; v.fl = fl; v.sp = sp; v.d = d;
    v.q0 = q0; v.q1 = q1; v.lv = LW'(lv); v.ov = ov; v.em = em; v.fu = fu;
    tv.push_back(v);
  endtask

  task automatic drive(input logic wb, ww, fl, sp, input logic [DW-1:0] d);
    wr_byte = wb; wr_word = ww; flush = fl; fhs = sp; data = d;
  endtask

  initial begin
    int nxt;
    mo = 1'b0;
    reset_n = 1'b0;
    drive(0, 0, 0, 0, '0);

    //   wb ww fl sp data      q0     q1     lv ov em fu
    add(0, 0, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 1, 0);
    add(0, 1, 0, 0, 16'hA1B2, 8'hA1, 8'hB2, 2, 0, 0, 0);
    add(0, 0, 0, 1, 16'h0000, 8'hB2, 8'hA1, 1, 0, 0, 0);
    add(0, 0, 0, 1, 16'h0000, 8'h00, 8'h00, 0, 0, 1, 0);
    add(0, 1, 0, 0, 16'h1234, 8'h12, 8'h34, 2, 0, 0, 0);
    add(0, 1, 0, 0, 16'h5678, 8'h12, 8'h34, 4, 0, 0, 1);
    add(1, 0, 0, 0, 16'h5555, 8'h12, 8'h34, 4, 1, 0, 1);
    add(0, 0, 1, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 1, 0);
    add(0, 1, 0, 0, 16'hA0B0, 8'hA0, 8'hB0, 2, 0, 0, 0);
    add(1, 0, 0, 0, 16'hC0C0, 8'hA0, 8'hB0, 3, 0, 0, 1);
    add(1, 0, 0, 1, 16'hD0D0, 8'hB0, 8'hA0, 3, 0, 0, 1);
    add(1, 0, 0, 0, 16'hE0E0, 8'hB0, 8'hA0, 4, 0, 0, 1);
    add(1, 0, 0, 1, 16'hF0F0, 8'hC0, 8'hC0, 3, 1, 0, 1);
    add(0, 1, 1, 0, 16'h9988, 8'h00, 8'h00, 0, 0, 1, 0);
    add(0, 0, 0, 1, 16'h0000, 8'h00, 8'h00, 0, 0, 1, 0);
    add(1, 1, 0, 0, 16'h1122, 8'h11, 8'h22, 1, 0, 0, 0);
    add(0, 1, 0, 0, 16'h3344, 8'h11, 8'h22, 3, 0, 0, 1);
    add(0, 1, 0, 0, 16'h5566, 8'h11, 8'h22, 3, 1, 0, 1);
    add(1, 1, 0, 0, 16'h7788, 8'h11, 8'h22, 4, 1, 0, 1);
    add(0, 0, 1, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    for (int d = 0; d < 2; d++) chk($sformatf("reset_pop%0d", d), 32'(pop_o[d]), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].wb, tv[i].ww, tv[i].fl, tv[i].sp, tv[i].d);
      cycle();
      chk($sformatf("vec%0d_q0", i), 32'(q_o[0]), 32'(tv[i].q0));
      chk($sformatf("vec%0d_q1", i), 32'(q_o[1]), 32'(tv[i].q1));
      chk($sformatf("vec%0d_level", i), 32'(level_o[0]), 32'(tv[i].lv));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf_o[0]), 32'(tv[i].ov));
      chk($sformatf("vec%0d_empty", i), 32'(empty_o[0]), 32'(tv[i].em));
      chk($sformatf("vec%0d_full", i), 32'(full_o[0]), 32'(tv[i].fu));
    end

    // Wrap: ten single bytes streamed through a 4-byte store with an irregular drain.
    for (int d = 0; d < 2; d++) drained[d].delete();
    nxt = 1;
    for (int c = 0; c < 60 && drained[0].size() < 10; c++) begin
      if (nxt <= 10) begin
        drive(1, 0, 0, (c % 3) != 0, {8'(nxt), 8'(nxt)});
        nxt++;
      end else begin
        drive(0, 0, 0, 1, '0);
      end
      cycle();
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("wrap_count%0d", d), 32'(drained[d].size()), 32'd10);
      for (int i = 0; i < 10 && i < drained[d].size(); i++)
        chk($sformatf("wrap%0d_byte%0d", d, i), 32'(drained[d][i]), 32'(i + 1));
    end

    // Randomised traffic against the model.
    for (int c = 0; c < 400; c++) begin
      drive(($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 23) == 0,
            ($urandom % 2) == 1, DW'($urandom));
      cycle();
    end

    // Asynchronous reset in the middle of a drain with overflow set.
    drive(0, 0, 1, 0, '0);     cycle();
    drive(0, 1, 0, 0, 16'h0102); cycle();
    drive(0, 1, 0, 0, 16'h0304); cycle();
    drive(1, 0, 0, 0, 16'h0505); cycle();
    chk("pre_reset_ovf", 32'(ovf_o[0]), 32'h1);
    drive(0, 0, 0, 1, '0);     cycle();
    #3;
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) mq[d].delete();
    mo = 1'b0;
    check_state("async_rst");
    for (int d = 0; d < 2; d++) chk($sformatf("async_rst_pop%0d", d), 32'(pop_o[d]), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish within bound");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
